egress_drain: RTL and testbench
===============================

// Module: egress_drain
// PURPOSE
//   Output-side consumer for the 4x4 router fabric: drains the four egress
//   xfifo instances (ports 4..7) round-robin and merges them onto one 10-bit
//   valid/ready stream. Drives the FIFO pops and tags each word with its
//   source port. Counts forwarded words and optionally checks each word's
//   destination field against the port it was drained from.
// PARAMETERS
//   DATA_W   10  word width; must equal the egress xfifo data width
//   CNT_W    8   width of the forwarded-word counter
//   DEST_LSB 8   LSB of the 2-bit destination field inside a word
// PORTS
//   clk        in   1       single clock; all logic on its rising edge
//   reset      in   1       asynchronous, active-low reset
//   fifo4_out..fifo7_out  in  DATA_W  egress FIFO read data
//   empty4..empty7        in  1       egress FIFO empty flags
//   pop4..pop7            out 1       egress FIFO pops (combinational)
//   data_out   out  DATA_W  merged word
//   src_id     out  2       source port of data_out (0 = FIFO4 .. 3 = FIFO7)
//   valid_out  out  1       data_out/src_id valid
//   ready_in   in   1       downstream accepts when valid_out & ready_in
//   word_cnt   out  CNT_W   words accepted downstream; wraps modulo 2^CNT_W
//   dest_err   out  1       sticky destination mismatch (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (reset=0, async): state=IDLE, rr_ptr=0, data_out=0, src_id=0,
//     valid_out=0, word_cnt=0, dest_err=0; all pops 0 while reset is low.
//   - FIFO read latency is 1: data is on fifoN_out in the cycle after popN.
//   - Grant: first non-empty port scanning rr_ptr, rr_ptr+1, ... (mod 4).
//     When granted, rr_ptr <= grant+1 (mod 4). At most one pop per cycle.
//     A pop is never asserted to a FIFO whose empty flag is high.
//   - FSM:
//     IDLE: any non-empty -> pop granted port, latch grant -> WAIT.
//           All empty -> stay IDLE.
//     WAIT: data_out <= fifo[grant]_out, src_id <= grant -> HOLD
//           (valid_out=1 from HOLD onwards).
//     HOLD: valid_out=1; data_out/src_id held stable while ready_in=0.
//           ready_in=1: word_cnt++; if any non-empty, pop granted port
//           this cycle -> WAIT (valid_out=0 next cycle); otherwise -> IDLE.
//   - Peak throughput: 1 word per 2 cycles. valid_out is never withdrawn
//     without a handshake.
//   - word_cnt wraps from 2^CNT_W-1 to 0 with no flag.
//   - empty changing during WAIT or HOLD has no effect until the next grant.
//   - Reset asserted in WAIT: the already-popped word is discarded. Reset
//     asserted in HOLD: the held word is dropped.
// CONFIGURATION
//   EGRESS_DEST_CHECK_EN defined:
//     In WAIT, compare word[DEST_LSB+1:DEST_LSB] with grant. On mismatch,
//     dest_err <= 1 and stays 1 until reset. The word is still forwarded.
//   Not defined:
//     dest_err is constant 0 and no compare logic is built.
//     All other behaviour is identical.
// TESTING
//   T1 reset: hold reset=0 with all FIFOs non-empty -> pops=0, valid_out=0,
//      word_cnt=0; first pop4 occurs in the first cycle after release.
//   T2 single word: FIFO5 holds 10'h1A5, others empty, ready_in=1 ->
//      pop5 at t0; data_out=10'h1A5, src_id=1, valid_out=1 at t0+2;
//      word_cnt=1.
//   T3 round-robin: all four FIFOs hold 2 words, ready_in=1 ->
//      src_id order 0,1,2,3,0,1,2,3; 8 words in 16 cycles; word_cnt=8.
//   T4 backpressure: ready_in=0 for 5 cycles in HOLD -> data_out stable,
//      no pops; ready_in=1 -> exactly one handshake, word_cnt+1.
//   T5 wrap and empty: CNT_W=8, push 257 words into FIFO7 -> word_cnt=1;
//      pop7 never asserted while empty7=1.
//   T6 dest check (EGRESS_DEST_CHECK_EN defined): word 10'h300 in FIFO4 ->
//      dest_err=1 from HOLD onwards and the word is still forwarded;
//      undefined: dest_err=0 throughout.

Source files
------------

// File: rtl/egress_drain.sv
// egress_drain: round-robin drain of egress FIFOs 4..7 onto one valid/ready stream.
// Define EGRESS_DEST_CHECK_EN to build the sticky destination-field check.
module egress_drain #(
  parameter int DATA_W   = 10,
  parameter int CNT_W    = 8,
  parameter int DEST_LSB = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] fifo4_out,
  input  logic [DATA_W-1:0] fifo5_out,
  input  logic [DATA_W-1:0] fifo6_out,
  input  logic [DATA_W-1:0] fifo7_out,
  input  logic              empty4,
  input  logic              empty5,
  input  logic              empty6,
  input  logic              empty7,
  output logic              pop4,
  output logic              pop5,
  output logic              pop6,
  output logic              pop7,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        src_id,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [CNT_W-1:0]  word_cnt,
  output logic              dest_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t            r_state;
  logic [1:0]        r_rr;
  logic [1:0]        r_gnt;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_src;
  logic              r_valid;
  logic [CNT_W-1:0]  r_cnt;

  logic [3:0]        w_req;
  logic [3:0]        w_pop;
  logic [1:0]        w_gnt;
  logic              w_any;
  logic              w_hs;
  logic              w_take;
  logic [DATA_W-1:0] w_word;

  if (DEST_LSB + 2 > DATA_W) begin : g_bad_dest
    $error("DEST_LSB places the destination field outside the word");
  end

  assign w_req  = ~{empty7, empty6, empty5, empty4};
  assign w_any  = |w_req;
  assign w_hs   = (r_state == S_HOLD) && ready_in;
  // A new pop is issued from IDLE or in the same cycle a held word is accepted.
  assign w_take = reset && w_any && ((r_state == S_IDLE) || w_hs);

  always_comb begin
    logic [1:0] v_idx;
    v_idx = '0;
    w_gnt = r_rr;
    for (int k = 3; k >= 0; k--) begin
      v_idx = r_rr + 2'(k);
      if (w_req[v_idx]) w_gnt = v_idx;
    end
  end

  assign w_pop = w_take ? (4'b0001 << w_gnt) : 4'b0000;
  assign {pop7, pop6, pop5, pop4} = w_pop;

  always_comb begin
    w_word = fifo4_out;
    unique case (r_gnt)
      2'd0: w_word = fifo4_out;
      2'd1: w_word = fifo5_out;
      2'd2: w_word = fifo6_out;
      2'd3: w_word = fifo7_out;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_rr    <= '0;
      r_gnt   <= '0;
      r_data  <= '0;
      r_src   <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_take) begin
        r_gnt <= w_gnt;
        r_rr  <= w_gnt + 2'd1;
      end
      unique case (r_state)
        S_IDLE: begin
          if (w_take) r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_data  <= w_word;
          r_src   <= r_gnt;
          r_valid <= 1'b1;
          r_state <= S_HOLD;
        end
        S_HOLD: begin
          if (ready_in) begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_valid <= 1'b0;
            r_state <= w_take ? S_WAIT : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data_out  = r_data;
  assign src_id    = r_src;
  assign valid_out = r_valid;
  assign word_cnt  = r_cnt;

`ifdef EGRESS_DEST_CHECK_EN
  logic r_derr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_derr <= 1'b0;
    end else if ((r_state == S_WAIT) &&
                 (w_word[DEST_LSB+1:DEST_LSB] != r_gnt)) begin
      r_derr <= 1'b1;
    end
  end

  assign dest_err = r_derr;
`else
  assign dest_err = 1'b0;
`endif

endmodule

// File: tb/tb_egress_drain.sv
// tb_egress_drain: randomized and directed bench for egress_drain with
// behavioural FIFO models and a round-robin / in-order scoreboard.
module tb_egress_drain;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] f_out [4];
  logic [3:0] emp;
  logic [3:0] pop;
  logic [9:0] data_out;
  logic [1:0] src_id;
  logic       valid_out;
  logic       ready_in;
  logic [7:0] word_cnt;
  logic       dest_err;

  always #5 clk = ~clk;

  egress_drain #(.DATA_W(10), .CNT_W(8), .DEST_LSB(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .fifo4_out (f_out[0]),
    .fifo5_out (f_out[1]),
    .fifo6_out (f_out[2]),
    .fifo7_out (f_out[3]),
    .empty4    (emp[0]),
    .empty5    (emp[1]),
    .empty6    (emp[2]),
    .empty7    (emp[3]),
    .pop4      (pop[0]),
    .pop5      (pop[1]),
    .pop6      (pop[2]),
    .pop7      (pop[3]),
    .data_out  (data_out),
    .src_id    (src_id),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .word_cnt  (word_cnt),
    .dest_err  (dest_err)
  );

`ifdef EGRESS_DEST_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic [9:0] fq [4][$];
  logic [9:0] exp_d [$];
  logic [1:0] exp_s [$];
  int         m_ptr;
  int         m_cnt;
  bit         m_derr;
  bit         prev_hold;
  logic [9:0] prev_d;
  logic [1:0] prev_s;
  int         cyc;
  int         n_vec;
  int         n_err;

  logic [3:0] s_pop;
  logic       s_valid;
  logic       s_hs;
  logic [9:0] s_data;
  logic [1:0] s_src;
  logic [7:0] s_cnt;
  logic       s_derr;

  function automatic logic [9:0] mkw(int p);
    logic [1:0] d;
    d = 2'(p);
    return {d, 8'($urandom)};
  endfunction

  function automatic bit busy();
    return (fq[0].size() + fq[1].size() + fq[2].size() + fq[3].size()
            + exp_d.size()) != 0;
  endfunction

  task automatic push(int p, logic [9:0] w);
    fq[p].push_back(w);
    emp[p] = 1'b0;
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_cnt = 0;
    m_derr = 1'b0;
    prev_hold = 1'b0;
    exp_d.delete();
    exp_s.delete();
  endtask

  // One clock: sample at negedge, score against the model, then update FIFOs.
  task automatic step();
    int e;
    int p;
    logic [3:0] ep;
    @(negedge clk);
    cyc++;
    s_pop = pop;
    s_valid = valid_out;
    s_data = data_out;
    s_src = src_id;
    s_cnt = word_cnt;
    s_derr = dest_err;
    s_hs = valid_out && ready_in;
    n_vec++;
    if ((pop & emp) != 4'b0 || $countones(pop) > 1) begin
      n_err++;
      $display("FAIL pop_legal: pop=%b empty=%b", pop, emp);
    end
    if (pop != 4'b0) begin
      e = -1;
      for (int k = 0; k < 4; k++)
        if (e < 0 && !emp[(m_ptr + k) % 4]) e = (m_ptr + k) % 4;
      ep = (e < 0) ? 4'b0 : 4'(1 << e);
      n_vec++;
      if (pop !== ep) begin
        n_err++;
        $display("FAIL rr_grant: pop=%b want=%b", pop, ep);
      end
      p = 0;
      for (int k = 3; k >= 0; k--) if (pop[k]) p = k;
      if (fq[p].size() > 0) begin
        exp_d.push_back(fq[p][0]);
        exp_s.push_back(2'(p));
      end
      m_ptr = (p + 1) % 4;
    end
    if (prev_hold) begin
      n_vec++;
      if (!valid_out || data_out !== prev_d || src_id !== prev_s) begin
        n_err++;
        $display("FAIL hold_stable: v=%b d=%h s=%0d want d=%h s=%0d",
                 valid_out, data_out, src_id, prev_d, prev_s);
      end
    end
    n_vec++;
    if (word_cnt !== 8'(m_cnt)) begin
      n_err++;
      $display("FAIL word_cnt: got %0d want %0d", word_cnt, 8'(m_cnt));
    end
    if (CHK && valid_out && exp_d.size() > 0)
      if (exp_d[0][9:8] != exp_s[0]) m_derr = 1'b1;
    n_vec++;
    if (dest_err !== m_derr) begin
      n_err++;
      $display("FAIL dest_err: got %b want %b", dest_err, m_derr);
    end
    if (valid_out) begin
      n_vec++;
      if (exp_d.size() == 0) begin
        n_err++;
        $display("FAIL spurious_valid: d=%h s=%0d", data_out, src_id);
      end else if (data_out !== exp_d[0] || src_id !== exp_s[0]) begin
        n_err++;
        $display("FAIL word: got d=%h s=%0d want d=%h s=%0d",
                 data_out, src_id, exp_d[0], exp_s[0]);
      end
    end
    if (s_hs) begin
      m_cnt++;
      if (exp_d.size() > 0) begin
        void'(exp_d.pop_front());
        void'(exp_s.pop_front());
      end
    end
    prev_hold = valid_out && !ready_in;
    prev_d = data_out;
    prev_s = src_id;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (s_pop[k] && fq[k].size() > 0) f_out[k] = fq[k].pop_front();
      emp[k] = (fq[k].size() == 0);
    end
  endtask

  task automatic drain(int bound);
    int n;
    n = 0;
    while (busy() && n < bound) begin
      step();
      n++;
    end
    n_vec++;
    if (busy()) begin
      n_err++;
      $display("FAIL drain_timeout: %0d words left after %0d cycles",
               exp_d.size() + fq[0].size() + fq[1].size() + fq[2].size()
               + fq[3].size(), bound);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    ready_in = 1'b1;
    for (int k = 0; k < 4; k++) push(k, mkw(k));
    @(posedge clk);
    #1;
    repeat (3) begin
      @(negedge clk);
      n_vec++;
      if (pop !== 4'b0 || valid_out !== 1'b0 || word_cnt !== 8'd0 ||
          data_out !== 10'd0 || src_id !== 2'd0 || dest_err !== 1'b0) begin
        n_err++;
        $display("FAIL reset_state: pop=%b v=%b cnt=%0d d=%h s=%0d de=%b",
                 pop, valid_out, word_cnt, data_out, src_id, dest_err);
      end
    end
    @(posedge clk);
    #1;
    model_reset();
    reset = 1'b1;
    step();
    n_vec++;
    if (s_pop !== 4'b0001) begin
      n_err++;
      $display("FAIL reset_first_pop: pop=%b want 0001", s_pop);
    end
    drain(60);
  endtask

  task automatic test_single();
    do_reset();
    ready_in = 1'b1;
    push(1, 10'h1A5);
    step();
    n_vec++;
    if (s_pop !== 4'b0010) begin
      n_err++;
      $display("FAIL single_pop: pop=%b want 0010", s_pop);
    end
    step();
    n_vec++;
    if (s_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_wait: valid=%b want 0", s_valid);
    end
    step();
    n_vec++;
    if (s_valid !== 1'b1 || s_data !== 10'h1A5 || s_src !== 2'd1) begin
      n_err++;
      $display("FAIL single_word: v=%b d=%h s=%0d want 1 1a5 1",
               s_valid, s_data, s_src);
    end
    step();
    n_vec++;
    if (s_cnt !== 8'd1 || s_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_cnt: cnt=%0d v=%b want 1 0", s_cnt, s_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] srcs [$];
    int first;
    int last;
    int n;
    do_reset();
    ready_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push(k, mkw(k));
      push(k, mkw(k));
    end
    first = -1;
    last = -1;
    n = 0;
    while (srcs.size() < 8 && n < 40) begin
      step();
      n++;
      if (s_pop != 4'b0 && first < 0) first = cyc;
      if (s_hs) begin
        srcs.push_back(s_src);
        last = cyc;
      end
    end
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (i >= srcs.size()) begin
        n_err++;
        $display("FAIL rr_order[%0d]: missing want %0d", i, i % 4);
      end else if (srcs[i] !== 2'(i % 4)) begin
        n_err++;
        $display("FAIL rr_order[%0d]: got %0d want %0d", i, srcs[i], i % 4);
      end
    end
    n_vec++;
    if (last - first != 16) begin
      n_err++;
      $display("FAIL rr_rate: got %0d cycles want 16", last - first);
    end
    step();
    n_vec++;
    if (s_cnt !== 8'd8) begin
      n_err++;
      $display("FAIL rr_cnt: got %0d want 8", s_cnt);
    end
  endtask

  task automatic test_backpressure();
    int p;
    int n;
    int c0;
    logic [9:0] held;
    ready_in = 1'b0;
    p = $urandom_range(0, 3);
    push(p, mkw(p));
    push((p + 1) % 4, mkw((p + 1) % 4));
    n = 0;
    s_valid = 1'b0;
    while (!s_valid && n < 10) begin
      step();
      n++;
    end
    held = s_data;
    c0 = m_cnt;
    repeat (5) begin
      step();
      n_vec++;
      if (s_pop !== 4'b0 || s_data !== held || s_valid !== 1'b1) begin
        n_err++;
        $display("FAIL bp_stall: pop=%b v=%b d=%h want 0000 1 %h",
                 s_pop, s_valid, s_data, held);
      end
    end
    ready_in = 1'b1;
    step();
    n_vec++;
    if (s_hs !== 1'b1) begin
      n_err++;
      $display("FAIL bp_accept: hs=%b want 1", s_hs);
    end
    step();
    n_vec++;
    if (s_valid !== 1'b0 || s_cnt !== 8'(c0 + 1)) begin
      n_err++;
      $display("FAIL bp_once: v=%b cnt=%0d want 0 %0d", s_valid, s_cnt,
               8'(c0 + 1));
    end
    drain(60);
  endtask

  task automatic test_random();
    int p;
    for (int i = 0; i < 400; i++) begin
      ready_in = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin
        p = $urandom_range(0, 3);
        push(p, ($urandom_range(0, 7) == 0) ? 10'($urandom) : mkw(p));
      end
      step();
    end
    ready_in = 1'b1;
    drain(400);
  endtask

  task automatic test_wrap();
    int n;
    do_reset();
    for (int i = 0; i < 257; i++) push(3, mkw(3));
    n = 0;
    while (busy() && n < 3000) begin
      ready_in = ($urandom_range(0, 3) != 0);
      step();
      n++;
    end
    ready_in = 1'b1;
    n_vec++;
    if (busy()) begin
      n_err++;
      $display("FAIL wrap_timeout: %0d cycles", n);
    end
    repeat (3) begin
      step();
      n_vec++;
      if (s_pop !== 4'b0 || s_cnt !== 8'd1) begin
        n_err++;
        $display("FAIL wrap_cnt: pop=%b cnt=%0d want 0000 1", s_pop, s_cnt);
      end
    end
  endtask

  task automatic test_dest();
    int n;
    do_reset();
    ready_in = 1'b1;
    push(0, 10'h300);
    n = 0;
    s_valid = 1'b0;
    while (!s_valid && n < 10) begin
      step();
      n++;
    end
    n_vec++;
    if (s_valid !== 1'b1 || s_data !== 10'h300 || s_src !== 2'd0 ||
        s_derr !== CHK) begin
      n_err++;
      $display("FAIL dest_word: v=%b d=%h s=%0d de=%b want 1 300 0 %b",
               s_valid, s_data, s_src, s_derr, CHK);
    end
    repeat (3) step();
    n_vec++;
    if (s_derr !== CHK || s_cnt !== 8'd1) begin
      n_err++;
      $display("FAIL dest_sticky: de=%b cnt=%0d want %b 1", s_derr, s_cnt,
               CHK);
    end
  endtask

  task automatic test_reset_hold();
    int n;
    do_reset();
    ready_in = 1'b0;
    push(2, mkw(2));
    push(3, mkw(3));
    n = 0;
    s_valid = 1'b0;
    while (!s_valid && n < 10) begin
      step();
      n++;
    end
    reset = 1'b0;
    #1;
    n_vec++;
    if (valid_out !== 1'b0 || pop !== 4'b0 || word_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL reset_hold: v=%b pop=%b cnt=%0d want 0 0000 0",
               valid_out, pop, word_cnt);
    end
    @(posedge clk);
    #1;
    do_reset();
    ready_in = 1'b1;
    drain(40);
    step();
    n_vec++;
    if (s_cnt !== 8'd1) begin
      n_err++;
      $display("FAIL reset_hold_cnt: cnt=%0d want 1", s_cnt);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc = 0;
    ready_in = 1'b0;
    emp = 4'hF;
    for (int k = 0; k < 4; k++) f_out[k] = '0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_random();
    test_wrap();
    test_dest();
    test_reset_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
